// File: rtl/lockstep_arb_pkg.sv
// Shared types and sizing helpers for the lockstep peripheral arbiter.
// Master indices are sized for the largest supported master count (8).
package lockstep_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_WIDTH   = $clog2(MAX_MASTERS);

  typedef logic [IDX_WIDTH-1:0] idx_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lockstep_arb_fifo.sv
// In-order routing FIFO holding the master index of every accepted request
// until the matching response returns. DEPTH must be a power of two.
module lockstep_arb_fifo
  import lockstep_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [IDX_WIDTH-1:0]        i_data,
  output logic [IDX_WIDTH-1:0]        o_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [occ_width(DEPTH)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  idx_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the count gates every
  // read, so stale entries are never observed and the array maps to plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/lockstep_periph_arbiter.sv
// Round-robin arbiter sharing the lockstep unit's peripheral slave port among
// NB_MASTERS requesters; responses are routed back in order via a FIFO.
module lockstep_periph_arbiter
  import lockstep_arb_pkg::*;
#(
  parameter int NB_MASTERS      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NB_MASTERS-1:0]                m_req_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0]     m_add_i,
  input  logic [NB_MASTERS-1:0]                m_wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
  input  logic [NB_MASTERS*(DATA_WIDTH/8)-1:0] m_be_i,
  input  logic [NB_MASTERS*ID_WIDTH-1:0]       m_id_i,
  output logic [NB_MASTERS-1:0]                m_gnt_o,
  output logic [NB_MASTERS-1:0]                m_r_valid_o,
  output logic                                 m_r_opc_o,
  output logic [ID_WIDTH-1:0]                  m_r_id_o,
  output logic [DATA_WIDTH-1:0]                m_r_rdata_o,
  output logic                                 s_req_o,
  output logic [ADDR_WIDTH-1:0]                s_add_o,
  output logic                                 s_wen_o,
  output logic [DATA_WIDTH-1:0]                s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]              s_be_o,
  output logic [ID_WIDTH-1:0]                  s_id_o,
  input  logic                                 s_gnt_i,
  input  logic                                 s_r_valid_i,
  input  logic                                 s_r_opc_i,
  input  logic [ID_WIDTH-1:0]                  s_r_id_i,
  input  logic [DATA_WIDTH-1:0]                s_r_rdata_i,
  output logic [occ_width(MAX_OUTSTANDING)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int BEW = DATA_WIDTH / 8;

  idx_t r_rr_ptr;
  logic r_err;
  idx_t w_winner;
  idx_t w_head;
  idx_t w_rr_next;
  int   w_dist;
  int   w_best;
  logic w_full;
  logic w_empty;
  logic w_s_req;
  logic w_hs;
  logic w_rsp;

  // Winner is the requester closest to r_rr_ptr going upward with wrap.
  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave a value held and infer a latch.
  always_comb begin
    w_winner = '0;
    w_best   = NB_MASTERS;
    w_dist   = 0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      w_dist = (i + NB_MASTERS - int'(r_rr_ptr)) % NB_MASTERS;
      if (m_req_i[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_winner = idx_t'(i);
      end
    end
  end

  // Fullness is registered state only; a same-cycle pop never frees a slot.
  assign w_s_req   = (|m_req_i) & ~w_full & ~rst_i;
  assign w_hs      = w_s_req & s_gnt_i;
  assign w_rsp     = s_r_valid_i & ~w_empty & ~rst_i;
  assign w_rr_next = (int'(w_winner) == NB_MASTERS - 1) ? '0 : w_winner + 1'b1;

  always_comb begin
    s_add_o     = '0;
    s_wen_o     = 1'b0;
    s_wdata_o   = '0;
    s_be_o      = '0;
    s_id_o      = '0;
    m_gnt_o     = '0;
    m_r_valid_o = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (idx_t'(i) == w_winner) begin
        s_add_o   = m_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wen_o   = m_wen_i[i];
        s_wdata_o = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_be_o    = m_be_i[i*BEW +: BEW];
        s_id_o    = m_id_i[i*ID_WIDTH +: ID_WIDTH];
      end
      m_gnt_o[i]     = w_hs & (idx_t'(i) == w_winner);
      m_r_valid_o[i] = w_rsp & (idx_t'(i) == w_head);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs) r_rr_ptr <= w_rr_next;
      if (s_r_valid_i && w_empty) r_err <= 1'b1;
    end
  end

  lockstep_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_hs),
    .i_pop   (w_rsp),
    .i_data  (w_winner),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding_o)
  );

  assign s_req_o     = w_s_req;
  assign m_r_opc_o   = s_r_opc_i;
  assign m_r_id_o    = s_r_id_i;
  assign m_r_rdata_o = s_r_rdata_i;
  assign err_o       = r_err;

endmodule
